// File: rtl/dc_mram_fifo_din.sv
// dc_mram_fifo_din
// Write-side stage of the MRAM dual-clock FIFO in the uDMA external-peripheral path.
// Words arrive on a valid/ready handshake and are stored in a register buffer.
// The buffer entry is chosen by a one-hot write token that rotates left on each accept.
// The token goes to the write-domain full detector. The buffer contents go to the read domain.
//
// Ports:
//   clk          write-domain clock
//   rstn         asynchronous active-low reset
//   data         word offered by the producer
//   valid        producer has a word on data
//   ready        block can accept a word this cycle (!full)
//   full         conservative full flag from the write-domain full detector
//   write_token  one-hot write pointer
//   buffer       flattened buffer; entry i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   pending      producer is stalled (valid && full); feeds the detector
//   clr_count    synchronous clear of word_count
//   word_count   words accepted since reset or last clear
//   token_err    sticky flag; write_token was seen not one-hot
module dc_mram_fifo_din #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,   // also the token-ring width; keep >= 4
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [DATA_WIDTH-1:0]              data,
  input  logic                               valid,
  output logic                               ready,
  input  logic                               full,
  output logic [BUFFER_DEPTH-1:0]            write_token,
  output logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer,
  output logic                               pending,
  input  logic                               clr_count,
  output logic [CNT_WIDTH-1:0]               word_count,
  output logic                               token_err
);

  logic                  accept;
  logic [DATA_WIDTH-1:0] buf_q [BUFFER_DEPTH];
  logic                  token_onehot;

  // The full detector is conservative: it covers pointer-synchronizer latency.
  // That means ready can follow it directly, with no extra register here.
  assign ready   = ~full;
  assign pending = valid & full;
  assign accept  = valid & ~full;

  // A token is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  assign token_onehot = (write_token != '0) &&
                        ((write_token & (write_token - BUFFER_DEPTH'(1))) == '0);

  // Token ring: rotate left on each accept.
  // A corrupted token is not repaired. token_err below flags it instead.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_token <= BUFFER_DEPTH'(1);
    end else if (accept) begin
      write_token <= {write_token[BUFFER_DEPTH-2:0], write_token[BUFFER_DEPTH-1]};
    end
  end

  // Buffer storage. Only the entry selected by the token is loaded.
  // The read domain samples the entries directly, so each one holds until overwritten.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        if (accept && write_token[i]) buf_q[i] <= data;
      end
    end
  end

  // Flatten the entries onto the buffer bus for the read side.
  for (genvar g = 0; g < BUFFER_DEPTH; g++) begin : g_flat
    assign buffer[g*DATA_WIDTH +: DATA_WIDTH] = buf_q[g];
  end

  // Accepted-word counter.
  // A clear on the same edge as an accept counts that accept, so the result is 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_count <= '0;
    end else if (clr_count) begin
      word_count <= accept ? CNT_WIDTH'(1) : '0;
    end else if (accept) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  // Sticky token-integrity flag. Only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      token_err <= 1'b0;
    end else if (!token_onehot) begin
      token_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dc_mram_fifo_din.sv
// tb_dc_mram_fifo_din
// Directed testbench for dc_mram_fifo_din.
// Each accepted word is pushed to a scoreboard when it is driven.
// The entry is popped and compared after the write edge.
module tb_dc_mram_fifo_din;

  localparam int DW = 32;
  localparam int BD = 8;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [DW-1:0]    data;
  logic             valid;
  logic             ready;
  logic             full;
  logic [BD-1:0]    write_token;
  logic [BD*DW-1:0] buffer;
  logic             pending;
  logic             clr_count;
  logic [CW-1:0]    word_count;
  logic             token_err;

  typedef struct {
    int          idx;
    logic [DW-1:0] d;
    logic [BD-1:0] tok;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sbq[$];
  int            testsRun = 0;
  int            failCount = 0;
  int            mIdx;
  logic [CW-1:0] mCnt;
  logic [DW-1:0] mBuf [BD];

  dc_mram_fifo_din #(.DATA_WIDTH(DW), .BUFFER_DEPTH(BD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .data(data), .valid(valid), .ready(ready),
    .full(full), .write_token(write_token), .buffer(buffer), .pending(pending),
    .clr_count(clr_count), .word_count(word_count), .token_err(token_err)
  );

  // Free-running write-domain clock.
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read entry i of the flattened buffer bus.
  function automatic logic [DW-1:0] entry(input int i);
    return buffer[i*DW +: DW];
  endfunction

  // Return the model token as a one-hot vector.
  function automatic logic [BD-1:0] mTok();
    logic [BD-1:0] t;
    t = '0;
    t[mIdx] = 1'b1;
    return t;
  endfunction

  // Assert reset and reset the model.
  // The DUT is checked asynchronously, before any clock edge.
  task automatic doReset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    mIdx = 0;
    mCnt = '0;
    for (int i = 0; i < BD; i++) mBuf[i] = '0;
    checkOutput("rst_token", 64'(write_token), 64'(8'h01));
    checkOutput("rst_count", 64'(word_count), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drive one word for a single edge.
  // When the model predicts acceptance, push the expectation to the scoreboard.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic clr);
    exp_t e;
    data = d;
    valid = 1'b1;
    clr_count = clr;
    if (!full) begin
      e.idx = mIdx;
      e.d = d;
      mBuf[mIdx] = d;
      mIdx = (mIdx + 1) % BD;
      mCnt = clr ? CW'(1) : mCnt + CW'(1);
      e.tok = mTok();
      e.cnt = mCnt;
      sbq.push_back(e);
    end else if (clr) begin
      mCnt = '0;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    clr_count = 1'b0;
  endtask

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic checkAccepted(input string tag);
    exp_t e;
    testsRun++;
    if (sbq.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
      return;
    end
    e = sbq.pop_front();
    checkOutput({tag, "_data"}, 64'(entry(e.idx)), 64'(e.d));
    checkOutput({tag, "_tok"}, 64'(write_token), 64'(e.tok));
    checkOutput({tag, "_cnt"}, 64'(word_count), 64'(e.cnt));
  endtask

  initial begin
    rstn = 1'b0;
    data = '0;
    valid = 1'b0;
    full = 1'b0;
    clr_count = 1'b0;
    mIdx = 0;
    mCnt = '0;
    for (int i = 0; i < BD; i++) mBuf[i] = '0;

    // Reset values.
    #12;
    checkOutput("reset_token", 64'(write_token), 64'h01);
    checkOutput("reset_count", 64'(word_count), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_err", 64'(token_err), 64'd0);
    checkOutput("reset_pending", 64'(pending), 64'd0);
    for (int i = 0; i < BD; i++) checkOutput($sformatf("reset_buf%0d", i), 64'(entry(i)), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single accept.
    applyStimulus(32'hA5A5_0001, 1'b0);
    checkAccepted("single");
    checkOutput("single_tok02", 64'(write_token), 64'h02);

    // Full wrap from a clean state, back-to-back.
    doReset();
    for (int i = 1; i <= BD; i++) begin
      applyStimulus(DW'(i), 1'b0);
      checkAccepted($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < BD; i++) checkOutput($sformatf("wrap_buf%0d", i), 64'(entry(i)), 64'(i + 1));
    checkOutput("wrap_tok01", 64'(write_token), 64'h01);
    checkOutput("wrap_cnt8", 64'(word_count), 64'd8);
    applyStimulus(32'd9, 1'b0);
    checkAccepted("wrap9");
    checkOutput("wrap9_buf0", 64'(entry(0)), 64'd9);

    // Backpressure: hold a word for 5 cycles while full is high.
    full = 1'b1;
    data = 32'h55;
    valid = 1'b1;
    #1;
    checkOutput("bp_ready", 64'(ready), 64'd0);
    checkOutput("bp_pending", 64'(pending), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_tok_c%0d", c), 64'(write_token), 64'(mTok()));
      checkOutput($sformatf("bp_buf_c%0d", c), 64'(entry(mIdx)), 64'(mBuf[mIdx]));
    end
    checkOutput("bp_cnt", 64'(word_count), 64'(mCnt));
    full = 1'b0;
    #1;
    checkOutput("bp_release_pending", 64'(pending), 64'd0);
    checkOutput("bp_release_ready", 64'(ready), 64'd1);
    applyStimulus(32'h55, 1'b0);
    checkAccepted("bp_accept");

    // Counter clear: run the count up to 37, then clear with and without an accept.
    while (mCnt != CW'(37)) begin
      applyStimulus($urandom, 1'b0);
      checkAccepted("cnt_fill");
    end
    checkOutput("cnt37", 64'(word_count), 64'd37);
    applyStimulus(32'hC1C1_C1C1, 1'b1);
    checkAccepted("clr_accept");
    checkOutput("clr_accept_is1", 64'(word_count), 64'd1);
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    mCnt = '0;
    checkOutput("clr_alone", 64'(word_count), 64'd0);

    // Counter wrap: 65535 streaming accepts reach 0xFFFF, and one more wraps to 0.
    data = 32'hDEAD_BEEF;
    valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    valid = 1'b0;
    for (int k = 0; k < 65535 % BD; k++) begin
      mBuf[mIdx] = 32'hDEAD_BEEF;
      mIdx = (mIdx + 1) % BD;
    end
    mCnt = 16'hFFFF;
    checkOutput("cnt_ffff", 64'(word_count), 64'hFFFF);
    checkOutput("cnt_ffff_tok", 64'(write_token), 64'(mTok()));
    applyStimulus(32'h0BAD_F00D, 1'b0);
    checkAccepted("cnt_wrap");
    checkOutput("cnt_wrap_zero", 64'(word_count), 64'd0);
    checkOutput("err_still0", 64'(token_err), 64'd0);

    // Mid-transfer reset, checked asynchronously between clock edges.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(DW'(32'h100 + i), 1'b0);
      checkAccepted("mid");
    end
    checkOutput("mid_tok08", 64'(write_token), 64'h08);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid_rst_tok", 64'(write_token), 64'h01);
    checkOutput("mid_rst_cnt", 64'(word_count), 64'd0);
    checkOutput("mid_rst_buf0", 64'(entry(0)), 64'd0);
    checkOutput("mid_rst_err", 64'(token_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    checkOutput("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/dc_mram_fifo_din.md
Name: dc_mram_fifo_din

Overview:
- Write-side (source-domain) stage of the MRAM dual-clock FIFO in the uDMA external-peripheral path.
- Accepts words over a valid/ready handshake and stores them in a BUFFER_DEPTH-entry register buffer.
- Advances a one-hot write token ring. The write token goes to the write-domain full detector; the buffer contents go to the read-domain side.
- Consumes the detector's conservative `full` flag to generate backpressure, and keeps an accepted-word counter for the transfer.

Parameters:
- DATA_WIDTH, 32, width of one FIFO word.
- BUFFER_DEPTH, 8, number of buffer entries and token-ring width. Must be >= 4.
- CNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- clk  input  1  write-domain clock.
- rstn  input  1  asynchronous active-low reset.
- data  input  DATA_WIDTH  word offered by the producer.
- valid  input  1  producer has a word on data.
- ready  output  1  block can accept a word this cycle.
- full  input  1  conservative full flag from the write-domain full detector.
- write_token  output  BUFFER_DEPTH  one-hot write pointer, to the full detector and the read side.
- buffer  output  BUFFER_DEPTH*DATA_WIDTH  flattened buffer; entry i is at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- pending  output  1  valid && !ready this cycle; drives the detector's valid input.
- clr_count  input  1  synchronous clear of word_count.
- word_count  output  CNT_WIDTH  number of words accepted since reset or clear.
- token_err  output  1  sticky flag: write_token was observed not one-hot.

Behaviour:
- **Clock and reset.** Single clock clk. Reset is asynchronous and active-low on rstn. All state is reset on rstn low.
- **Reset values:**
  - write_token = 'b0...01 (bit 0 set).
  - every buffer entry = 0.
  - word_count = 0.
  - token_err = 0.
  - ready = !full (combinational; no register of its own).
- **Handshake:**
  - ready = !full, combinational.
  - A word is accepted on a rising clk edge when valid && ready.
  - The producer must hold data stable while valid && !ready.
  - valid may drop without acceptance; nothing is written.
- **Write on accept:**
  - The buffer entry at the single set bit of write_token is loaded with data.
  - In the same edge, write_token rotates left by one: bit i -> bit i+1, bit BUFFER_DEPTH-1 -> bit 0.
  - Write latency is one cycle. The new entry and the new token are both visible after the accepting edge.
- **No accept.** Token and buffer hold their values.
- **Full semantics:**
  - full asserts while 3 or fewer entries are free, to cover pointer-synchronizer latency.
  - The block never writes while full = 1.
  - Full detection itself is not re-derived here.
- **Wrap-around.** After BUFFER_DEPTH accepts, write_token returns to bit 0. There is no other wrap state.
- **pending.** Combinational valid && full. The detector latches it to hold full while the producer is stalled.
- **word_count:**
  - Increments by 1 per accept and wraps modulo 2^CNT_WIDTH.
  - clr_count alone -> 0.
  - clr_count on the same edge as an accept -> 1.
- **token_err.** Set if write_token is ever zero or has more than one bit set. Cleared only by reset; the token is not auto-repaired.
- **Reset mid-transfer.** Token returns to bit 0 immediately. The read side must be reset together with this block; the FIFO contents are discarded.

Test Plan:
- **Reset values.** Reset, full=0, valid=0 -> write_token=0x01, word_count=0, ready=1, buffer all zero, token_err=0.
- **Single accept.** data=0xA5A5_0001, valid=1 for one cycle -> buffer entry 0 = 0xA5A5_0001, write_token=0x02, word_count=1.
- **Full wrap.** 8 back-to-back accepts of data 1..8 -> entries 0..7 = 1..8, write_token back to 0x01, word_count=8. A 9th word (9) overwrites entry 0.
- **Backpressure:**
  - Raise full with valid=1 and data=0x55 -> ready=0, pending=1, token and buffer unchanged for 5 cycles.
  - Drop full -> 0x55 is accepted on the next edge and pending goes to 0.
- **Counter clear.** clr_count and an accept on the same edge with word_count=37 -> word_count=1. clr_count alone -> 0. With CNT_WIDTH=16, an accept at 0xFFFF -> 0x0000.
- **Mid-transfer reset.** Assert rstn low after 3 accepts (token=0x08) -> write_token=0x01 and word_count=0 asynchronously, before the next clk edge.
